plru_replacer: RTL

Parametrised tree pseudo-LRU replacement unit for the N-way set-associative caches.
- Holds (WAYS-1) tree bits per set.
- Picks a victim way on a miss and updates recency on every hit or fill.
- Adds set-clear sequencing, flush, multi-hit detection and registered responses.
- Sits between the tag-compare stage and the line-fill controller.

---
 rtl/plru_pkg.sv | 52 +++++
 rtl/plru_replacer_if.sv | 48 ++++
 rtl/plru_tree_walk.sv | 76 +++++++
 rtl/plru_replacer.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/plru_pkg.sv
// Shared types and helpers for the tree pseudo-LRU replacer.
// Helpers work on vectors sized for the largest supported associativity (16 ways).
package plru_pkg;

    localparam int MAX_WAYS  = 16;
    localparam int MAX_WAY_W = 4;

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    // Heap-ordered tree: node n has children 2n and 2n+1.
    function automatic int node_parent(int n);
        return n >> 1;
    endfunction

    function automatic int node_child(int n, logic dir);
        return 2 * n + int'(dir);
    endfunction

    // Node visited by `way` at depth `level` (root is depth 0).
    function automatic int node_of_way(int way, int level, int levels);
        return (1 << level) + (way >> (levels - level));
    endfunction

    // Direction taken at depth `level` on the way's path: 0 = lower half, 1 = upper half.
    function automatic logic path_bit(int way, int level, int levels);
        return 1'((way >> (levels - 1 - level)) & 1);
    endfunction

    function automatic logic [MAX_WAY_W:0] popcount(logic [MAX_WAYS-1:0] v);
        logic [MAX_WAY_W:0] c;
        c = '0;
        for (int i = 0; i < MAX_WAYS; i++) begin
            c = c + (MAX_WAY_W + 1)'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [MAX_WAY_W-1:0] onehot2bin(logic [MAX_WAYS-1:0] v);
        logic [MAX_WAY_W-1:0] b;
        b = '0;
        for (int i = 0; i < MAX_WAYS; i++) begin
            if (v[i]) begin
                b = b | MAX_WAY_W'(i);
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/plru_replacer_if.sv
// Request/response bundle between tag compare, replacer and line-fill controller.
// PLRU_WAY_LOCK_EN adds the per-way lock mask and the no-fill response flag.
interface plru_replacer_if #(
    parameter int WAYS = 4,
    parameter int SETS = 64
);
    localparam int WAY_W   = $clog2(WAYS);
    localparam int INDEX_W = $clog2(SETS);

    logic               flush;
    logic               req_valid;
    logic [INDEX_W-1:0] req_index;
    logic [WAYS-1:0]    req_hit;
    logic [WAYS-1:0]    req_line_valid;
    logic               req_ready;
    logic               rsp_valid;
    logic               rsp_hit;
    logic [WAYS-1:0]    rsp_victim_oh;
    logic [WAY_W-1:0]   rsp_victim_id;
    logic               rsp_multihit;
    logic               init_done;
`ifdef PLRU_WAY_LOCK_EN
    logic [WAYS-1:0]    lock_mask;
    logic               rsp_nofill;

    modport master (
        output flush, req_valid, req_index, req_hit, req_line_valid, lock_mask,
        input  req_ready, rsp_valid, rsp_hit, rsp_victim_oh, rsp_victim_id,
               rsp_multihit, init_done, rsp_nofill
    );
    modport slave (
        input  flush, req_valid, req_index, req_hit, req_line_valid, lock_mask,
        output req_ready, rsp_valid, rsp_hit, rsp_victim_oh, rsp_victim_id,
               rsp_multihit, init_done, rsp_nofill
    );
`else
    modport master (
        output flush, req_valid, req_index, req_hit, req_line_valid,
        input  req_ready, rsp_valid, rsp_hit, rsp_victim_oh, rsp_victim_id,
               rsp_multihit, init_done
    );
    modport slave (
        input  flush, req_valid, req_index, req_hit, req_line_valid,
        output req_ready, rsp_valid, rsp_hit, rsp_victim_oh, rsp_victim_id,
               rsp_multihit, init_done
    );
`endif
endinterface

// File: rtl/plru_tree_walk.sv
// Combinational victim selection: lowest usable invalid way first, otherwise
// the leaf reached by following tree bits, steering around fully locked subtrees.
module plru_tree_walk
    import plru_pkg::*;
#(
    parameter  int WAYS  = 4,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]  tree_i,
    input  logic [WAYS-1:0]  line_valid_i,
    input  logic [WAYS-1:0]  lock_i,
    output logic [WAYS-1:0]  victim_oh_o,
    output logic [WAY_W-1:0] victim_id_o,
    output logic             none_o
);

    // Invalid-way scan, then root-to-leaf walk with lock steering.
    always_comb begin
        int   way;
        int   node;
        int   base;
        int   span;
        logic found;
        logic dir;
        logic lo_locked;
        logic hi_locked;

        way       = 0;
        node      = 1;
        base      = 0;
        span      = WAYS;
        found     = 1'b0;
        dir       = 1'b0;
        lo_locked = 1'b0;
        hi_locked = 1'b0;

        for (int w = 0; w < WAYS; w++) begin
            if (!found && !line_valid_i[w] && !lock_i[w]) begin
                found = 1'b1;
                way   = w;
            end
        end

        if (!found) begin
            for (int l = 0; l < WAY_W; l++) begin
                span      = span / 2;
                lo_locked = 1'b1;
                hi_locked = 1'b1;
                for (int w = 0; w < WAYS; w++) begin
                    if (w >= base && w < base + span && !lock_i[w]) begin
                        lo_locked = 1'b0;
                    end
                    if (w >= base + span && w < base + 2 * span && !lock_i[w]) begin
                        hi_locked = 1'b0;
                    end
                end
                dir = tree_i[node-1];
                if (!dir && lo_locked) begin
                    dir = 1'b1;
                end else if (dir && hi_locked) begin
                    dir = 1'b0;
                end
                if (dir) begin
                    base = base + span;
                end
                node = node_child(node, dir);
            end
            way = base;
        end

        none_o      = &lock_i;
        victim_id_o = none_o ? '0 : WAY_W'(way);
        victim_oh_o = none_o ? '0 : (WAYS'(1) << way);
    end

endmodule

// File: rtl/plru_replacer.sv
// Tree pseudo-LRU replacement unit: per-set tree storage, init/flush clearing
// sequencer, touch logic and registered responses.
// Optional feature macro: PLRU_WAY_LOCK_EN (per-way lock mask, rsp_nofill).
module plru_replacer
    import plru_pkg::*;
#(
    parameter int WAYS = 4,
    parameter int SETS = 64
) (
    input  logic           clk,
    input  logic           rst,
    plru_replacer_if.slave bus
);

    localparam int WAY_W   = $clog2(WAYS);
    localparam int INDEX_W = $clog2(SETS);

    state_e             state_q;
    logic [INDEX_W-1:0] cnt_q;
    logic [WAYS-2:0]    tree_q [SETS];
    logic               ready_q;
    logic               done_q;
    logic               rsp_valid_q;
    logic               rsp_hit_q;
    logic               rsp_multi_q;
    logic [WAYS-1:0]    rsp_oh_q;
    logic [WAY_W-1:0]   rsp_id_q;

    logic [WAYS-1:0]    lock;
    logic [WAYS-2:0]    tree_rd;
    logic [WAYS-2:0]    tree_d;
    logic               accept;
    logic               hit_any;
    logic               multi;
    logic [WAYS-1:0]    hit_oh;
    logic [WAY_W-1:0]   hit_id;
    logic [WAYS-1:0]    walk_oh;
    logic [WAY_W-1:0]   walk_id;
    logic               walk_none;
    logic               nofill;
    logic [WAY_W-1:0]   touch_way;

`ifdef PLRU_WAY_LOCK_EN
    logic               rsp_nofill_q;
    assign lock           = bus.lock_mask;
    assign bus.rsp_nofill = rsp_nofill_q;
`else
    assign lock = '0;
`endif

    assign tree_rd   = tree_q[bus.req_index];
    assign accept    = bus.req_valid && ready_q && !bus.flush;
    assign hit_any   = |bus.req_hit;
    assign multi     = popcount(MAX_WAYS'(bus.req_hit)) > (MAX_WAY_W + 1)'(1);
    assign hit_oh    = bus.req_hit & (~bus.req_hit + WAYS'(1));
    assign hit_id    = WAY_W'(onehot2bin(MAX_WAYS'(hit_oh)));
    assign nofill    = !hit_any && walk_none;
    assign touch_way = hit_any ? hit_id : walk_id;

    plru_tree_walk #(
        .WAYS (WAYS)
    ) u_walk (
        .tree_i       (tree_rd),
        .line_valid_i (bus.req_line_valid),
        .lock_i       (lock),
        .victim_oh_o  (walk_oh),
        .victim_id_o  (walk_id),
        .none_o       (walk_none)
    );

    // Touch: every node on the touched way's path points away from it.
    always_comb begin
        tree_d = tree_rd;
        for (int l = 0; l < WAY_W; l++) begin
            tree_d[node_of_way(int'(touch_way), l, WAY_W) - 1] = ~path_bit(int'(touch_way), l, WAY_W);
        end
    end

    // Control FSM (INIT clears one set per cycle, RUN accepts) and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= INIT;
            cnt_q        <= '0;
            ready_q      <= 1'b0;
            done_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_multi_q  <= 1'b0;
            rsp_oh_q     <= '0;
            rsp_id_q     <= '0;
`ifdef PLRU_WAY_LOCK_EN
            rsp_nofill_q <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= accept;
            if (accept) begin
                rsp_hit_q    <= hit_any;
                rsp_multi_q  <= multi;
                rsp_oh_q     <= hit_any ? '0 : walk_oh;
                rsp_id_q     <= hit_any ? '0 : walk_id;
`ifdef PLRU_WAY_LOCK_EN
                rsp_nofill_q <= nofill;
`endif
            end
            case (state_q)
                INIT: begin
                    if (bus.flush) begin
                        cnt_q <= '0;
                    end else if (cnt_q == INDEX_W'(SETS - 1)) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + INDEX_W'(1);
                    end
                end
                RUN: begin
                    if (bus.flush) begin
                        state_q <= INIT;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

    // Tree storage: cleared during INIT, written with touched bits on accept.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            tree_q[cnt_q] <= '0;
        end else if (accept && !nofill) begin
            tree_q[bus.req_index] <= tree_d;
        end
    end

    assign bus.req_ready     = ready_q;
    assign bus.init_done     = done_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_hit       = rsp_hit_q;
    assign bus.rsp_victim_oh = rsp_oh_q;
    assign bus.rsp_victim_id = rsp_id_q;
    assign bus.rsp_multihit  = rsp_multi_q;

endmodule
